wts_tone_generator_mc: RTL and testbench
========================================

WTS_TONE_GENERATOR_MC -- requirements
Module: wts_tone_generator_mc

Interface
REQ-001 Parameter CH_NUM, default 5, number of time-multiplexed channels (2..8).
REQ-002 Parameter FREQ_W, default 12, width of frequency register and per-channel counter.
REQ-003 Parameter ADDR_W, default 5, width of per-channel wave address (table depth 2^ADDR_W).
REQ-004 Parameter CH_W, default 3, width of the channel index; SHALL satisfy 2^CH_W >= CH_NUM.
REQ-005 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-006 nreset  input  1  reset; asynchronous, active-low.
REQ-007 enable  input  1  slot tick; one channel is processed per cycle with enable=1.
REQ-008 freq_we  input  1  frequency register write strobe.
REQ-009 freq_ch  input  CH_W  channel selected by freq_we.
REQ-010 freq_data  input  FREQ_W  frequency period value to write.
REQ-011 key_on  input  CH_NUM  per-channel run enable, bit n = channel n.
REQ-012 ch_index  output  CH_W  channel whose address is on wave_address.
REQ-013 wave_address  output  ADDR_W  wave table address for ch_index.
REQ-014 wave_valid  output  1  wave_address/ch_index valid this cycle.

Function
REQ-015 Slot counter SHALL step 0,1,...,CH_NUM-1,0 on each enable=1 cycle; hold when enable=0.
REQ-016 Per channel the block SHALL hold freq_reg[FREQ_W], count[FREQ_W], addr[ADDR_W] in register arrays.
REQ-017 On an enable cycle for slot s with key_on[s]=1 and freq_reg[s]!=0: if count[s]==freq_reg[s] then count[s]<=0 and addr[s]<=addr[s]+1 (modulo 2^ADDR_W); else count[s]<=count[s]+1.
REQ-018 Channel s with key_on[s]=0 SHALL have count[s] and addr[s] set to 0 on its slot visit.
REQ-019 Channel s with freq_reg[s]==0 and key_on[s]=1 SHALL hold count[s] and addr[s] (halted).
REQ-020 Count compare SHALL be full FREQ_W equality; count SHALL never exceed freq_reg except after a freq_reg decrease, where it SHALL wrap modulo 2^FREQ_W and continue incrementing until equality.
REQ-021 Outputs registered: cycle after an enable cycle for slot s, wave_valid=1, ch_index=s, wave_address=addr[s] value before that visit's update; otherwise wave_valid=0, ch_index/wave_address hold.
REQ-022 freq_we=1 SHALL write freq_data into freq_reg[freq_ch] at the clock edge, regardless of enable; freq_ch>=CH_NUM SHALL be ignored.
REQ-023 Write to the channel processed in the same cycle: update SHALL use old freq_reg; new value effective from next visit.
REQ-024 key_on changes SHALL take effect at the channel's next slot visit only.

Reset
REQ-025 nreset=0 SHALL asynchronously clear slot counter, all freq_reg, count, addr, and outputs (ch_index=0, wave_address=0, wave_valid=0).
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence; first enable after release processes slot 0.

Configuration
REQ-027 Macro WTS_TONE_PHASE_RESET_EN defined: freq_we to channel c SHALL also clear count[c] and addr[c] at that edge, overriding any same-cycle update of c by REQ-017.
REQ-028 Macro undefined: freq_we SHALL affect freq_reg only; count/addr continue undisturbed.

Verification
REQ-029 Reset, CH_NUM=5, enable held 1, no key_on -> wave_valid=1 each cycle after first, ch_index 0,1,2,3,4,0, wave_address=0.
REQ-030 freq_reg[2]=3, key_on[2]=1, enable=1 -> addr[2] increments once every 4 visits to slot 2 (every 20 enable cycles); after 32 increments wave_address returns to 0.
REQ-031 freq_reg[1]=0, key_on[1]=1 after running -> wave_address for ch 1 frozen; then key_on[1]=0 -> reads 0 on the visit after next.
REQ-032 freq_we to ch 3 on the same edge slot 3 reaches count==old freq -> addr[3] increments using old value; with WTS_TONE_PHASE_RESET_EN, count[3]=0 and addr[3]=0 instead.
REQ-033 enable toggled 1/0 alternately -> slot advances only on enable=1; wave_valid pulses one cycle after each enable.
REQ-034 nreset pulsed low while ch_index=3 -> all outputs 0 immediately; next processed slot is 0.

Source files
------------

// File: rtl/wts_tone_generator_mc.sv
// Time-multiplexed wave table address generator: one channel slot per enable tick.
// Optional macro WTS_TONE_PHASE_RESET_EN: a frequency write also restarts that channel's phase.
module wts_tone_generator_mc #(
  parameter int CH_NUM = 5,
  parameter int FREQ_W = 12,
  parameter int ADDR_W = 5,
  parameter int CH_W   = 3
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              enable,
  input  logic              freq_we,
  input  logic [CH_W-1:0]   freq_ch,
  input  logic [FREQ_W-1:0] freq_data,
  input  logic [CH_NUM-1:0] key_on,
  output logic [CH_W-1:0]   ch_index,
  output logic [ADDR_W-1:0] wave_address,
  output logic              wave_valid
);

  logic [CH_W-1:0]   slot;
  logic [ADDR_W-1:0] slot_addr;
  logic [FREQ_W-1:0] freq_reg  [CH_NUM];
  logic [FREQ_W-1:0] count     [CH_NUM];
  logic [FREQ_W-1:0] count_nxt [CH_NUM];
  logic [ADDR_W-1:0] addr      [CH_NUM];
  logic [ADDR_W-1:0] addr_nxt  [CH_NUM];

  // Only the channel in the current slot advances; the compare uses the pre-write freq_reg.
  always_comb begin
    slot_addr = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      count_nxt[c] = count[c];
      addr_nxt[c]  = addr[c];
      if (slot == CH_W'(c)) begin
        slot_addr = addr[c];
      end
      if (enable && slot == CH_W'(c)) begin
        if (!key_on[c]) begin
          count_nxt[c] = '0;
          addr_nxt[c]  = '0;
        end else if (freq_reg[c] != '0) begin
          if (count[c] == freq_reg[c]) begin
            count_nxt[c] = '0;
            addr_nxt[c]  = addr[c] + ADDR_W'(1);
          end else begin
            count_nxt[c] = count[c] + FREQ_W'(1);
          end
        end
      end
`ifdef WTS_TONE_PHASE_RESET_EN
      if (freq_we && freq_ch == CH_W'(c)) begin
        count_nxt[c] = '0;
        addr_nxt[c]  = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot         <= '0;
      wave_valid   <= 1'b0;
      ch_index     <= '0;
      wave_address <= '0;
    end else begin
      wave_valid <= enable;
      if (enable) begin
        ch_index     <= slot;
        wave_address <= slot_addr;
        slot         <= (slot == CH_W'(CH_NUM - 1)) ? '0 : slot + CH_W'(1);
      end
    end
  end

  // Writes to channel numbers >= CH_NUM match no entry and are dropped.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int c = 0; c < CH_NUM; c++) begin
        freq_reg[c] <= '0;
        count[c]    <= '0;
        addr[c]     <= '0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        count[c] <= count_nxt[c];
        addr[c]  <= addr_nxt[c];
        if (freq_we && freq_ch == CH_W'(c)) begin
          freq_reg[c] <= freq_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_wts_tone_generator_mc.sv
// Randomized bench for wts_tone_generator_mc against a per-visit arithmetic model.
// Follows WTS_TONE_PHASE_RESET_EN when it is defined for the build.
module tb_wts_tone_generator_mc;
  localparam int CH_NUM = 5;
  localparam int FREQ_W = 12;
  localparam int ADDR_W = 5;
  localparam int CH_W   = 3;

  logic              clk;
  logic              nreset;
  logic              enable;
  logic              freq_we;
  logic [CH_W-1:0]   freq_ch;
  logic [FREQ_W-1:0] freq_data;
  logic [CH_NUM-1:0] key_on;
  logic [CH_W-1:0]   ch_index;
  logic [ADDR_W-1:0] wave_address;
  logic              wave_valid;

  int checks = 0;
  int errors = 0;

  int m_slot = 0;
  int m_freq  [8] = '{default: 0};
  int m_count [8] = '{default: 0};
  int m_addr  [8] = '{default: 0};
  int exp_valid = 0;
  int exp_ch    = 0;
  int exp_addr  = 0;

  int visits;
  int found;
  int prev_addr;
  logic [CH_NUM-1:0] rkey;

  wts_tone_generator_mc #(
    .CH_NUM(CH_NUM), .FREQ_W(FREQ_W), .ADDR_W(ADDR_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .freq_we(freq_we),
    .freq_ch(freq_ch), .freq_data(freq_data), .key_on(key_on),
    .ch_index(ch_index), .wave_address(wave_address), .wave_valid(wave_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: each slot visit is a small integer step on that channel's phase.
  initial begin
    forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) begin
        m_slot = 0;
        exp_valid = 0; exp_ch = 0; exp_addr = 0;
        for (int c = 0; c < 8; c++) begin
          m_freq[c] = 0; m_count[c] = 0; m_addr[c] = 0;
        end
      end else begin
        exp_valid = enable ? 1 : 0;
        if (enable) begin
          exp_ch   = m_slot;
          exp_addr = m_addr[m_slot];
          if (!key_on[m_slot]) begin
            m_count[m_slot] = 0;
            m_addr[m_slot]  = 0;
          end else if (m_freq[m_slot] != 0) begin
            if (m_count[m_slot] == m_freq[m_slot]) begin
              m_count[m_slot] = 0;
              m_addr[m_slot]  = (m_addr[m_slot] + 1) % (1 << ADDR_W);
            end else begin
              m_count[m_slot] = (m_count[m_slot] + 1) % (1 << FREQ_W);
            end
          end
          m_slot = (m_slot + 1) % CH_NUM;
        end
        if (freq_we && int'(freq_ch) < CH_NUM) begin
          m_freq[freq_ch] = int'(freq_data);
`ifdef WTS_TONE_PHASE_RESET_EN
          m_count[freq_ch] = 0;
          m_addr[freq_ch]  = 0;
`endif
        end
      end
    end
  end

  task automatic checkOutput();
    checks++;
    if (int'(wave_valid) != exp_valid || int'(ch_index) != exp_ch ||
        int'(wave_address) != exp_addr) begin
      errors++;
      $display("[TB] FAIL model_compare t=%0t got valid=%0d ch=%0d addr=%0d expected valid=%0d ch=%0d addr=%0d",
               $time, wave_valid, ch_index, wave_address, exp_valid, exp_ch, exp_addr);
    end
  endtask

  task automatic checkLiteral(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic we, input logic [CH_W-1:0] ch,
                               input logic [FREQ_W-1:0] data, input logic [CH_NUM-1:0] key);
    @(negedge clk);
    enable = en; freq_we = we; freq_ch = ch; freq_data = data; key_on = key;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput();
    end
  end

  initial begin
    enable = 1'b0; freq_we = 1'b0; freq_ch = '0; freq_data = '0; key_on = '0;
    nreset = 1'b1;
    #1 nreset = 1'b0;
    #2;
    checkLiteral("reset_valid", int'(wave_valid), 0);
    checkLiteral("reset_ch", int'(ch_index), 0);
    checkLiteral("reset_addr", int'(wave_address), 0);
    @(negedge clk);
    nreset = 1'b1;

    $display("[TB] slot sweep with no keys");
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkLiteral("sweep_ch", int'(ch_index), i % CH_NUM);
      checkLiteral("sweep_valid", int'(wave_valid), 1);
      checkLiteral("sweep_addr", int'(wave_address), 0);
    end

    $display("[TB] channel 2 period 4 visits");
    applyStimulus(1'b0, 1'b1, 3'd2, 12'd3, '0);
    applyStimulus(1'b1, 1'b0, '0, '0, 5'b00100);
    freq_we = 1'b0;
    visits = 0;
    for (int i = 0; i < 800 && visits < 129; i++) begin
      @(negedge clk);
      if (wave_valid && ch_index == 3'd2) begin
        visits++;
        if (visits == 5)   checkLiteral("ch2_visit5", int'(wave_address), 1);
        if (visits == 125) checkLiteral("ch2_visit125", int'(wave_address), 31);
        if (visits == 129) checkLiteral("ch2_wrap", int'(wave_address), 0);
      end
    end
    checkLiteral("ch2_visit_budget", visits, 129);

    $display("[TB] halt and key release on channel 1");
    applyStimulus(1'b0, 1'b1, 3'd1, 12'd2, 5'b00110);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, '0, '0, 5'b00110);
    applyStimulus(1'b1, 1'b1, 3'd1, 12'd0, 5'b00110);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, '0, '0, 5'b00110);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, '0, '0, 5'b00100);

    $display("[TB] same-edge write on channel 3");
    applyStimulus(1'b1, 1'b1, 3'd3, 12'd1, 5'b01000);
    found = 0;
    prev_addr = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk);
      if (m_slot == 3 && m_count[3] == m_freq[3] && m_freq[3] != 0 && i > 6) begin
        found = 1;
        prev_addr = m_addr[3];
        freq_we = 1'b1; freq_ch = 3'd3; freq_data = 12'd2;
      end else begin
        freq_we = 1'b0;
      end
    end
    @(negedge clk);
    freq_we = 1'b0;
    checkLiteral("same_edge_found", found, 1);
    checkLiteral("same_edge_out_ch", int'(ch_index), 3);
    checkLiteral("same_edge_out_addr", int'(wave_address), prev_addr);
    checkLiteral("same_edge_freq", m_freq[3], 2);
    checkLiteral("same_edge_count", m_count[3], 0);
`ifdef WTS_TONE_PHASE_RESET_EN
    checkLiteral("same_edge_addr", m_addr[3], 0);
`else
    checkLiteral("same_edge_addr", m_addr[3], (prev_addr + 1) % 32);
`endif

    $display("[TB] alternating enable");
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2) == 0, 1'b0, '0, '0, 5'b01100);
      @(posedge clk);
      #1 checkLiteral("toggle_valid", int'(wave_valid), (i % 2) == 0 ? 1 : 0);
    end

    $display("[TB] randomized traffic");
    rkey = 5'b10101;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rkey = CH_NUM'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    CH_W'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) == 0) ? FREQ_W'($urandom) : FREQ_W'($urandom_range(0, 6)),
                    rkey);
    end

    $display("[TB] reset mid-sequence");
    applyStimulus(1'b1, 1'b0, '0, '0, 5'b11111);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (wave_valid && ch_index == 3'd3) found = 1;
    end
    checkLiteral("reach_ch3", found, 1);
    #2 nreset = 1'b0;
    #1;
    checkLiteral("midreset_valid", int'(wave_valid), 0);
    checkLiteral("midreset_ch", int'(ch_index), 0);
    checkLiteral("midreset_addr", int'(wave_address), 0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    checkLiteral("after_reset_ch", int'(ch_index), 0);
    checkLiteral("after_reset_valid", int'(wave_valid), 1);
    @(negedge clk);
    checkLiteral("after_reset_ch_next", int'(ch_index), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
